// File: rtl/gen_crd_pkg.sv
// Shared helpers for the credit-based flow-control link (sender and receiver sides).
// Width functions let both ends size their counters and grant buses identically.
package gen_crd_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int grnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

  function automatic int crd_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/gen_crd_rcv_fifo.sv
// Receiver target buffer: DEPTH-entry FIFO with first-word fall-through read.
// Pointers wrap explicitly, so DEPTH need not be a power of two.
module gen_crd_rcv_fifo
  import gen_crd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_en_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_en_i,
  output logic              push_acc_o,
  output logic              pop_acc_o,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign empty_o    = (cnt_q == {CNT_W{1'b0}});
  assign push_acc_o = push_en_i & ~full_o;
  assign pop_acc_o  = pop_en_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign cnt_o      = cnt_q;

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = push_acc_o ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_acc_o ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_acc_o, pop_acc_o})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately left unreset; contents are meaningless while empty
  always_ff @(posedge clk) begin
    if (push_acc_o) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/gen_crd_rcv_top.sv
// Credit receiver: buffers sender words and returns freed entries as grant pulses.
// Credits are accumulated from local pops and released by threshold or drain flush.
module gen_crd_rcv_top
  import gen_crd_pkg::*;
#(
  parameter int DATA_W           = 8,
  parameter int DEPTH            = 8,
  parameter int MAX_CRD_GRNT_VAL = 1,
  parameter int RTN_THRESH       = 1,
  localparam int CNT_W           = cnt_w(DEPTH),
  localparam int CRD_GRNT_W      = grnt_w(MAX_CRD_GRNT_VAL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_en,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop_en,
  output logic [DATA_W-1:0]     pop_data,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [CNT_W-1:0]      fifo_cnt,
  output logic [CNT_W-1:0]      pend_crd,
  output logic                  crd_grnt_en,
  output logic [CRD_GRNT_W-1:0] crd_grnt_val,
  output logic                  ovf_err,
  output logic                  udf_err
);

  logic                  push_acc_s, pop_acc_s;
  logic                  rtn_go_s;
  logic [CRD_GRNT_W-1:0] rtn_amt_s;
  logic [CNT_W-1:0]      pend_crd_q, pend_crd_d;
  logic                  grnt_en_q, grnt_en_d;
  logic [CRD_GRNT_W-1:0] grnt_val_q, grnt_val_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;

  gen_crd_rcv_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_en_i   (push_en),
    .push_data_i (push_data),
    .pop_en_i    (pop_en),
    .push_acc_o  (push_acc_s),
    .pop_acc_o   (pop_acc_s),
    .pop_data_o  (pop_data),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .cnt_o       (fifo_cnt)
  );

  // Return decision; the empty term flushes leftovers when the threshold exceeds 1
  always_comb begin
    rtn_go_s   = (pend_crd_q >= CNT_W'(RTN_THRESH)) |
                 (fifo_empty & (pend_crd_q != {CNT_W{1'b0}}));
    rtn_amt_s  = CRD_GRNT_W'(crd_min(int'(pend_crd_q), MAX_CRD_GRNT_VAL));
    pend_crd_d = pend_crd_q + CNT_W'(pop_acc_s)
                 - (rtn_go_s ? CNT_W'(rtn_amt_s) : {CNT_W{1'b0}});
    grnt_en_d  = rtn_go_s;
    grnt_val_d = rtn_go_s ? rtn_amt_s : {CRD_GRNT_W{1'b0}};
    ovf_d      = ovf_q | (push_en & ~push_acc_s);
    udf_d      = udf_q | (pop_en & ~pop_acc_s);
  end

  // Credit accumulator, registered grant outputs and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_crd_q <= {CNT_W{1'b0}};
      grnt_en_q  <= 1'b0;
      grnt_val_q <= {CRD_GRNT_W{1'b0}};
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      pend_crd_q <= pend_crd_d;
      grnt_en_q  <= grnt_en_d;
      grnt_val_q <= grnt_val_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign pend_crd     = pend_crd_q;
  assign crd_grnt_en  = grnt_en_q;
  assign crd_grnt_val = grnt_val_q;
  assign ovf_err      = ovf_q;
  assign udf_err      = udf_q;

endmodule

// File: doc/gen_crd_rcv_top.md
Name: gen_crd_rcv_top

Overview:
- Receiver end of the credit-based flow-control link. The sender-side credit manager consumes credits; this block owns the target buffer and returns credits to it.
- Buffers words from a credit-gated sender in an internal FIFO of DEPTH entries.
- Counts entries freed by local pops and returns them as grant pulses (value plus enable) that connect directly to the sender's grant inputs.
- Sender's initial credit amount must equal DEPTH.

Parameters:
- DATA_W, 8, data word width [bits]
- DEPTH, 8, FIFO depth; equals the sender's initial credit amount; any value ≥ 2, not required to be a power of 2
- MAX_CRD_GRNT_VAL, 1, maximum credits returned in one grant pulse; range 1..DEPTH
- RTN_THRESH, 1, pending-credit level that triggers a return; range 1..DEPTH
- (local) CNT_W = $clog2(DEPTH)+1; CRD_GRNT_W = $clog2(MAX_CRD_GRNT_VAL)+1; PTR_W = $clog2(DEPTH)

Ports:
- clk, input, 1, clock
- rst_n, input, 1, asynchronous active-low reset
- push_en, input, 1, sender writes a word (sender holds a credit)
- push_data, input, DATA_W, write data
- pop_en, input, 1, local consumer reads a word
- pop_data, output, DATA_W, head-of-FIFO data, first-word fall-through
- fifo_empty, output, 1, FIFO holds no words
- fifo_full, output, 1, fifo_cnt == DEPTH
- fifo_cnt, output, CNT_W, current occupancy
- pend_crd, output, CNT_W, credits freed but not yet returned
- crd_grnt_en, output, 1, credit return pulse, registered
- crd_grnt_val, output, CRD_GRNT_W, number of credits returned; 0 when crd_grnt_en = 0
- ovf_err, output, 1, sticky: a push arrived while full
- udf_err, output, 1, sticky: a pop arrived while empty

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - wr_ptr, rd_ptr, fifo_cnt, pend_crd, crd_grnt_en, crd_grnt_val, ovf_err, udf_err all = 0; fifo_empty = 1.
  - Storage contents are not reset; pop_data is don't-care while empty.
  - Reset mid-operation discards buffered words and pending credits. The sender shares this reset domain and restores its own initial credits.
- Push acceptance: push_acc = push_en & ~fifo_full. Writes mem[wr_ptr].
  - Push while full is rejected even if a pop happens in the same cycle; the data is dropped and ovf_err is set.
  - This never occurs under the credit protocol and indicates a protocol violation.
- Pop acceptance: pop_acc = pop_en & ~fifo_empty. Pop while empty is ignored and udf_err is set.
- Pointers: advance by 1 on acceptance; wrap from DEPTH-1 to 0.
- fifo_cnt update: +1 on push_acc only; -1 on pop_acc only; unchanged when both or neither.
- Simultaneous push and pop on a non-full, non-empty FIFO: both are accepted and order is preserved.
- A push into an empty FIFO is visible on pop_data the next cycle.
- Return decision, combinational on registered state:
  - rtn_go = (pend_crd ≥ RTN_THRESH) | (fifo_empty & pend_crd ≠ 0). The second term is a drain flush so the sender never starves when the threshold is above 1.
  - rtn_amt = min(pend_crd, MAX_CRD_GRNT_VAL).
- pend_crd update: pend_crd_next = pend_crd + pop_acc − (rtn_go ? rtn_amt : 0).
  - Pop and return in the same cycle combine in a single update.
  - Invariant: fifo_cnt + pend_crd + credits in flight at the sender ≤ DEPTH. pend_crd never exceeds DEPTH and cannot wrap.
- Grant outputs (registered): crd_grnt_en <= rtn_go; crd_grnt_val <= rtn_go ? rtn_amt : 0.
- Latency:
  - Pop accepted in cycle N → pend_crd updated in N+1.
  - Earliest grant pulse in N+2 (threshold met in N+1).
  - Back-to-back grant pulses are allowed.
- Error flags: ovf_err and udf_err clear only on reset. Errors do not alter credit accounting.

Decomposition:
- Package gen_crd_pkg holds:
  - width helper functions (cnt_w(depth), grnt_w(max)) shared with the sender-side manager;
  - a min() function.
- Sub-module gen_crd_rcv_fifo: storage plus pointers, count, full/empty, and first-word fall-through read. It exposes push_acc and pop_acc.
- The top level keeps the credit accumulator, return logic and error flags.

Test Plan:
1. Reset asserted mid-traffic with fifo_cnt = 5, pend_crd = 3 → immediately fifo_cnt = 0, pend_crd = 0, fifo_empty = 1, crd_grnt_en = 0, errors = 0.
2. DEPTH = 8: 9 consecutive pushes, no pops → fifo_full = 1 after the 8th, 9th word dropped, ovf_err = 1 and stays 1, fifo_cnt = 8; 8 pops then return words 0..7 in order.
3. THRESH = 2, MAX = 2, fifo_cnt = 8: pop at N, pop at N+1 → pend_crd = 1 at N+1, 2 at N+2; crd_grnt_en = 1 with val = 2 at N+3; pend_crd = 0 at N+3.
4. THRESH = 4, fifo_cnt = 1: single pop at N → fifo_empty at N+1 with pend_crd = 1; flush grant val = 1 at N+2.
5. THRESH = 1, MAX = 2, fifo_cnt = 8: pop every cycle for 4 cycles → grant pulses val = 1 each cycle from N+2 to N+5; sum of crd_grnt_val = 4; pend_crd = 0 afterwards; fifo_cnt = 4.
6. fifo_cnt = 3, simultaneous push + pop → fifo_cnt stays 3, FIFO order intact. Separately, pop_en while empty → udf_err = 1, pend_crd unchanged.
